fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Control end of the EX-stage operand forwarding muxes: generates the 2-bit selects
//  (00 = register file, 01 = MEM/WB writeback data, 10 = EX/MEM ALU result) for ALU
//  operands A and B. Also detects load-use hazards and stalls PC/IF-ID.
//  Tracks destination regs of in-flight instrs in its own ID/EX, EX/MEM and MEM/WB
//  shadow registers. Sits beside the ID/EX pipeline register.
// PARAMETERS
//  REG_AW   5   register address width
//  CNT_W    32  width of stall counter (HAZ_STALL_CNT_EN only)
// PORTS
//  clk          in   1        pipeline clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  id_valid     in   1        ID holds a real instruction
//  id_rs        in   REG_AW   ID source reg A
//  id_rt        in   REG_AW   ID source reg B
//  id_uses_rs   in   1        ID instr reads rs
//  id_uses_rt   in   1        ID instr reads rt
//  id_rd        in   REG_AW   ID destination reg (post RegDst mux)
//  id_regwrite  in   1        ID instr writes a register
//  id_memread   in   1        ID instr is a load
//  ex_flush     in   1        branch/jump resolved taken: squash ID->EX
//  fwd_a_sel    out  2        select for EX operand A mux
//  fwd_b_sel    out  2        select for EX operand B mux
//  stall        out  1        load-use stall (ID->EX bubble inserted)
//  pc_write     out  1        PC update enable (= ~stall)
//  ifid_write   out  1        IF/ID update enable (= ~stall)
//  stall_cnt    out  CNT_W    stall cycles counted (HAZ_STALL_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): all shadow stages invalid (rs/rt/rd=0, regwrite=memread=0);
//   fwd_a_sel=fwd_b_sel=2'b00, stall=0, pc_write=1, ifid_write=1, stall_cnt=0.
//  Shadow pipeline, every rising clk:
//   MEM/WB <= EX/MEM; EX/MEM <= ID/EX;
//   ID/EX <= bubble if (stall | ex_flush | ~id_valid), else {id_rs,id_rt,rs/rt uses,
//   id_rd, id_regwrite, id_memread}. Bubble: regwrite=0, memread=0, uses=0, regs=0.
//  Forward select (combinational from shadow flops only, no input paths):
//   A: 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs & ex_uses_rs;
//      else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs & ex_uses_rs; else 00.
//   B: same with ex_rt/ex_uses_rt. EX/MEM beats MEM/WB on double match.
//   Reg 0 never forwarded. 2'b11 never driven.
//  Load-use stall (combinational): stall=1 when ex_memread & ex_rd!=0 & id_valid &
//   ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)) & ~ex_flush.
//   Lasts exactly 1 cycle: bubble enters ID/EX, load moves to EX/MEM and is then
//   covered by MEM/WB forwarding (sel 01) one cycle later.
//  ex_flush overrides stall: stall=0, ID/EX gets bubble, EX/MEM and MEM/WB advance.
//  Load whose rd is 0 never stalls. Back-to-back loads with chained deps stall once each.
//  Reset mid-stall: stall drops immediately (async), in-flight state discarded.
// CONFIGURATION
//  HAZ_STALL_CNT_EN defined: stall_cnt increments by 1 on each clk with stall=1,
//   wraps modulo 2^CNT_W, cleared only by reset.
//  Not defined: stall_cnt port absent, no counter flops.
// TESTING
//  1 add r3 then add r4,r3,r3 -> next cycle fwd_a_sel=fwd_b_sel=10, stall=0.
//  2 add r3, nop, sub r5,r3,r1 -> sub in EX: fwd_a_sel=01, fwd_b_sel=00.
//  3 lw r2 then add r6,r2,r7 -> stall=1 one cycle, pc_write=0; then add in EX with
//    fwd_a_sel=01; stall_cnt=1 when HAZ_STALL_CNT_EN.
//  4 add r8 / add r8 / or r9,r8,r8 -> or in EX: both sels=10 (newest wins).
//  5 lw r0 then add r1,r0,r0 -> stall=0, sels=00; add r0 then use r0 -> sels=00.
//  6 lw r2 + dependent in ID with ex_flush=1 -> stall=0, bubble; rst_n low mid-stall
//    -> stall=0, sels=00 asynchronously.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
//   Pipeline -> unit : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
//                      id_regwrite, id_memread, ex_flush
//   Unit -> pipeline : fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write,
//                      stall_cnt (only when HAZ_STALL_CNT_EN is defined)
// Modports: master = pipeline side, slave = fwd_hazard_unit.
// Optional feature macro: HAZ_STALL_CNT_EN (adds the stall_cnt signal).
// -----------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic              pc_write;
    logic              ifid_write;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, ex_flush,
        input  fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, ex_flush,
        output fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write, stall_cnt
    );
`else
    // Counter width only matters when the counter exists.
    localparam int cnt_w_unused = CNT_W;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, ex_flush,
        input  fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_regwrite, id_memread, ex_flush,
        output fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write
    );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Control end of the EX-stage operand forwarding muxes plus load-use hazard
// detection. Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB
// register-usage fields so forwarding selects come from flops only.
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fwd_hazard_unit_if.slave
//            in : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
//                 id_regwrite, id_memread, ex_flush
//            out: fwd_a_sel, fwd_b_sel (00 regfile, 01 MEM/WB, 10 EX/MEM),
//                 stall, pc_write, ifid_write, stall_cnt (optional)
// Optional feature macro: HAZ_STALL_CNT_EN -> free-running stall-cycle counter.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fwd_hazard_unit_if.slave     bus
);

    // ID/EX shadow
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              ex_uses_rs_q;
    logic              ex_uses_rt_q;
    logic              ex_regwrite_q;
    logic              ex_memread_q;
    // EX/MEM and MEM/WB shadows: only the destination matters downstream
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_regwrite_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              wb_regwrite_q;

    logic              stall_d;
    logic              bubble_d;
    logic              rs_dep;
    logic              rt_dep;

    // Load-use: the load in EX cannot supply data until it reaches MEM/WB,
    // so a dependent instruction in ID must wait one cycle. A taken branch
    // squashes the ID instruction anyway, so it never stalls.
    assign rs_dep   = bus.id_uses_rs && (bus.id_rs == ex_rd_q);
    assign rt_dep   = bus.id_uses_rt && (bus.id_rt == ex_rd_q);
    assign stall_d  = ex_memread_q && (ex_rd_q != '0) && bus.id_valid
                      && (rs_dep || rt_dep) && !bus.ex_flush;
    assign bubble_d = stall_d || bus.ex_flush || !bus.id_valid;

    assign bus.stall      = stall_d;
    assign bus.pc_write   = !stall_d;
    assign bus.ifid_write = !stall_d;

    // Forward selects for operand A (index 0) and B (index 1). The EX/MEM
    // producer is newer than the MEM/WB one, so it is tested first.
    logic [1:0][REG_AW-1:0] ex_src;
    logic [1:0]             ex_uses;
    logic [1:0][1:0]        fwd_sel;

    assign ex_src  = {ex_rt_q, ex_rs_q};
    assign ex_uses = {ex_uses_rt_q, ex_uses_rs_q};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            assign mem_hit = mem_regwrite_q && (mem_rd_q != '0)
                             && (mem_rd_q == ex_src[gi]) && ex_uses[gi];
            assign wb_hit  = wb_regwrite_q && (wb_rd_q != '0)
                             && (wb_rd_q == ex_src[gi]) && ex_uses[gi];
            assign fwd_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
        end
    endgenerate

    assign bus.fwd_a_sel = fwd_sel[0];
    assign bus.fwd_b_sel = fwd_sel[1];

    // Shadow pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_rd_q        <= '0;
            ex_uses_rs_q   <= 1'b0;
            ex_uses_rt_q   <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            wb_rd_q        <= mem_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            if (bubble_d) begin
                ex_rs_q       <= '0;
                ex_rt_q       <= '0;
                ex_rd_q       <= '0;
                ex_uses_rs_q  <= 1'b0;
                ex_uses_rt_q  <= 1'b0;
                ex_regwrite_q <= 1'b0;
                ex_memread_q  <= 1'b0;
            end else begin
                ex_rs_q       <= bus.id_rs;
                ex_rt_q       <= bus.id_rt;
                ex_rd_q       <= bus.id_rd;
                ex_uses_rs_q  <= bus.id_uses_rs;
                ex_uses_rt_q  <= bus.id_uses_rt;
                ex_regwrite_q <= bus.id_regwrite;
                ex_memread_q  <= bus.id_memread;
            end
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Wraps naturally modulo 2^CNT_W.
    assign stall_cnt_d = stall_d ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // An instruction as the reference model sees it.
    typedef struct {
        int rs;
        int rt;
        bit uses_rs;
        bit uses_rt;
        int rd;
        bit writes;
        bit load;
    } instr_t;

    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        bit         stall;
        bit [CNT_W-1:0] cnt;
    } exp_t;

    // In-flight instructions, youngest first: [0]=EX, [1]=MEM, [2]=WB.
    instr_t flight[$];
    exp_t   exp_q[$];
    instr_t cur;
    bit     cur_valid;
    bit     cur_flush;
    bit     stalled;
    bit [CNT_W-1:0] cnt;

    int total = 0;
    int bad   = 0;

    function automatic instr_t nothing();
        instr_t n;
        n.rs = 0; n.rt = 0; n.uses_rs = 0; n.uses_rt = 0;
        n.rd = 0; n.writes = 0; n.load = 0;
        return n;
    endfunction

    task automatic model_reset();
        flight = {};
        repeat (3) flight.push_back(nothing());
        cnt     = '0;
        stalled = 1'b0;
    endtask

    function automatic bit reads(instr_t c, int r);
        return (c.uses_rs && c.rs == r) || (c.uses_rt && c.rt == r);
    endfunction

    // Find the newest older instruction that writes the source register.
    function automatic logic [1:0] fwd_for(int src, bit used);
        if (!used || src == 0) return 2'b00;
        for (int k = 1; k <= 2; k++)
            if (flight[k].writes && flight[k].rd == src)
                return (k == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit load_use();
        return flight[0].load && flight[0].rd != 0 && cur_valid
               && reads(cur, flight[0].rd) && !cur_flush;
    endfunction

    task automatic check(string nm, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // One clock: the model advances with the held inputs, then new ID inputs
    // are applied and the expected outputs for that cycle are queued.
    task automatic issue(bit v, int rs, int rt, bit urs, bit urt,
                         int rd, bit w, bit ld, bit fl);
        exp_t e;
        @(posedge clk);
        if (stalled) cnt = cnt + 1'b1;
        void'(flight.pop_back());
        flight.push_front((stalled || cur_flush || !cur_valid) ? nothing() : cur);
        #1;
        cur.rs = rs; cur.rt = rt; cur.uses_rs = urs; cur.uses_rt = urt;
        cur.rd = rd; cur.writes = w; cur.load = ld;
        cur_valid = v;
        cur_flush = fl;
        bus.id_valid    = v;
        bus.id_rs       = REG_AW'(rs);
        bus.id_rt       = REG_AW'(rt);
        bus.id_uses_rs  = urs;
        bus.id_uses_rt  = urt;
        bus.id_rd       = REG_AW'(rd);
        bus.id_regwrite = w;
        bus.id_memread  = ld;
        bus.ex_flush    = fl;
        stalled = load_use();
        e.fa    = fwd_for(flight[0].rs, flight[0].uses_rs);
        e.fb    = fwd_for(flight[0].rt, flight[0].uses_rt);
        e.stall = stalled;
        e.cnt   = cnt;
        exp_q.push_back(e);
        $display("issue v=%0b rs=%0d rt=%0d rd=%0d w=%0b ld=%0b fl=%0b -> a=%0b b=%0b stall=%0b",
                 v, rs, rt, rd, w, ld, fl, e.fa, e.fb, e.stall);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // R-type: rd <- rs op rt
    task automatic alu(int rd, int rs, int rt);
        issue(1, rs, rt, 1, 1, rd, 1, 0, 0);
    endtask

    // Load: rd <- mem[rs]
    task automatic lw(int rd, int rs);
        issue(1, rs, 0, 1, 0, rd, 1, 1, 0);
    endtask

    // Monitor: compare whatever the DUT presents in each cycle against the
    // oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("fwd_a_sel",  64'(bus.fwd_a_sel),  64'(e.fa));
            check("fwd_b_sel",  64'(bus.fwd_b_sel),  64'(e.fb));
            check("stall",      64'(bus.stall),      64'(e.stall));
            check("pc_write",   64'(bus.pc_write),   64'(!e.stall));
            check("ifid_write", 64'(bus.ifid_write), 64'(!e.stall));
`ifdef HAZ_STALL_CNT_EN
            check("stall_cnt",  64'(bus.stall_cnt),  64'(e.cnt));
`endif
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_fwd_a"},    64'(bus.fwd_a_sel),  64'd0);
        check({tag, "_fwd_b"},    64'(bus.fwd_b_sel),  64'd0);
        check({tag, "_stall"},    64'(bus.stall),      64'd0);
        check({tag, "_pc_write"}, 64'(bus.pc_write),   64'd1);
        check({tag, "_ifid_wr"},  64'(bus.ifid_write), 64'd1);
`ifdef HAZ_STALL_CNT_EN
        check({tag, "_cnt"},      64'(bus.stall_cnt),  64'd0);
`endif
    endtask

    initial begin
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_rd = '0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.ex_flush = 0;
        cur = nothing();
        cur_valid = 0;
        cur_flush = 0;
        model_reset();

        #2;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;

        // add r3 -> add r4,r3,r3 : both operands from EX/MEM
        alu(3, 1, 2); alu(4, 3, 3); nop(); nop(); nop();
        // add r3, nop, sub r5,r3,r1 : A from MEM/WB
        alu(3, 1, 2); nop(); alu(5, 3, 1); nop(); nop(); nop();
        // lw r2 -> add r6,r2,r7 : one stall then MEM/WB forward
        lw(2, 1); alu(6, 2, 7); alu(6, 2, 7); nop(); nop(); nop();
        // add r8 / add r8 / or r9,r8,r8 : newest producer wins
        alu(8, 1, 1); alu(8, 2, 2); alu(9, 8, 8); nop(); nop(); nop();
        // register 0 never stalls nor forwards
        lw(0, 1); alu(1, 0, 0); nop(); alu(0, 1, 1); alu(2, 0, 0); nop(); nop(); nop();
        // back-to-back loads with chained deps
        lw(2, 1); lw(3, 2); lw(3, 2); alu(4, 3, 3); alu(4, 3, 3); nop(); nop(); nop();
        // flush overrides the load-use stall
        lw(2, 1); issue(1, 2, 7, 1, 1, 6, 1, 0, 1); nop(); nop(); nop();

        // asynchronous reset in the middle of a stall
        lw(2, 1); alu(6, 2, 7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_stall");
        model_reset();
        #1 rst_n = 1'b1;
        nop(); nop();

        // randomized traffic over a small register window to force hits
        for (int i = 0; i < 400; i++) begin
            bit v, fl, ld;
            v  = ($urandom_range(0, 99) < 85);
            fl = ($urandom_range(0, 99) < 10);
            ld = ($urandom_range(0, 99) < 30);
            issue(v, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 80, ld, fl);
        end
        nop(); nop(); nop();

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
            check("drain_left", 64'(exp_q.size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
